// File: rtl/reg_file_rv32.sv
// RV32I integer register file: 32 x DATA_WIDTH registers, x0 hardwired to zero,
// two combinational read ports with write-through bypass, one synchronous write port.
module reg_file_rv32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [ADDR_WIDTH-1:0] addr_rd1,
  input  logic [ADDR_WIDTH-1:0] addr_rd2,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd1,
  output logic [DATA_WIDTH-1:0] data_rd2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_reg_file [0:DEPTH-1];
  logic                  w_wr_valid;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // Writes to x0 are dropped; an unknown wr_en falls through to "no write".
  always_comb begin
    w_wr_valid = 1'b0;
    if (wr_en == 1'b1 && addr_wr != '0) begin
      w_wr_valid = 1'b1;
    end
  end

  // rst_n is active-high here: asserting it clears the whole array at once.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_reg_file[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_reg_file[addr_wr] <= data_wr;
    end
  end

  // Read port 1: zero under reset or for x0, bypass on same-cycle write.
  always_comb begin
    w_rd1 = '0;
    if (!rst_n && addr_rd1 != '0) begin
      if (w_wr_valid && addr_wr == addr_rd1) begin
        w_rd1 = data_wr;
      end else begin
        w_rd1 = r_reg_file[addr_rd1];
      end
    end
  end

  always_comb begin
    w_rd2 = '0;
    if (!rst_n && addr_rd2 != '0) begin
      if (w_wr_valid && addr_wr == addr_rd2) begin
        w_rd2 = data_wr;
      end else begin
        w_rd2 = r_reg_file[addr_rd2];
      end
    end
  end

  assign data_rd1 = w_rd1;
  assign data_rd2 = w_rd2;

endmodule

// File: tb/tb_reg_file_rv32.sv
// Directed and random checks for reg_file_rv32: reset, write/read, x0,
// bypass, write-enable gating, reset during write, and a model-checked random run.
module tb_reg_file_rv32;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  addr_wr;
  logic [4:0]  addr_rd1;
  logic [4:0]  addr_rd2;
  logic [31:0] data_wr;
  logic [31:0] data_rd1;
  logic [31:0] data_rd2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [0:31];

  typedef struct {
    logic        we;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [12];

  reg_file_rv32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .addr_wr  (addr_wr),
    .addr_rd1 (addr_rd1),
    .addr_rd2 (addr_rd2),
    .data_wr  (data_wr),
    .data_rd1 (data_rd1),
    .data_rd2 (data_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic we,
                                         input logic [4:0] aw, input logic [31:0] dw);
    if (a == 5'd0) return 32'h0;
    if (we && aw == a) return dw;
    return model[a];
  endfunction

  initial begin
    int wr_left;
    int rd_left;
    int wr_gap;
    int rd_gap;
    int cyc;

    // Hand-computed vectors: inputs are applied, checked combinationally, then clocked.
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h00001111, 5'd7,  5'd5,  32'h00001111, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 5'd7,  32'h00002222, 5'd7,  5'd7,  32'h00002222, 32'h00002222};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h00002222, 32'h00002222};
    vecs[7]  = '{1'b1, 5'd9,  32'hABCD0001, 5'd9,  5'd31, 32'hABCD0001, 32'h0};
    vecs[8]  = '{1'b0, 5'd9,  32'h00001234, 5'd9,  5'd9,  32'hABCD0001, 32'hABCD0001};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd7,  32'hABCD0001, 32'h00002222};
    vecs[10] = '{1'b1, 5'd31, 32'h80000000, 5'd31, 5'd1,  32'h80000000, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h80000000, 32'h80000000};

    rst_n = 1'b0; wr_en = 1'b0; addr_wr = '0; addr_rd1 = '0; addr_rd2 = '0; data_wr = '0;

    // Reset clears a randomly preloaded array, without a clock edge.
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.r_reg_file[i] = $urandom | 32'h1;
    addr_rd1 = 5'd5; addr_rd2 = 5'd17;
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_hold_rd1", data_rd1, 32'h0);
    chk("reset_hold_rd2", data_rd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_rd1 = 5'(i); addr_rd2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_clear_rd1[%0d]", i), data_rd1, 32'h0);
      chk($sformatf("reset_clear_rd2[%0d]", 31 - i), data_rd2, 32'h0);
    end

    // Table-driven directed vectors.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      wr_en = vecs[v].we; addr_wr = vecs[v].aw; data_wr = vecs[v].dw;
      addr_rd1 = vecs[v].r1; addr_rd2 = vecs[v].r2;
      #1;
      chk($sformatf("vec%0d_rd1", v), data_rd1, vecs[v].e1);
      chk($sformatf("vec%0d_rd2", v), data_rd2, vecs[v].e2);
    end

    // Reset asserted during a write: reset wins and the bypass is suppressed.
    @(negedge clk);
    wr_en = 1'b1; addr_wr = 5'd3; data_wr = 32'h55555555;
    addr_rd1 = 5'd3; addr_rd2 = 5'd31;
    rst_n = 1'b1;
    #1;
    chk("rst_wr_rd1", data_rd1, 32'h0);
    chk("rst_wr_rd2", data_rd2, 32'h0);
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b0;
    #1;
    chk("rst_wr_after_x3", data_rd1, 32'h0);
    chk("rst_wr_after_x31", data_rd2, 32'h0);

    // Random run against a model, starting from a backdoor preload.
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      model[i] = $urandom;
      dut.r_reg_file[i] = model[i];
    end
    model[0] = 32'h0;
    wr_left = 10; rd_left = 10;
    wr_gap = int'($urandom_range(3, 1)); rd_gap = int'($urandom_range(4, 1));
    cyc = 0;
    while ((wr_left > 0 || rd_left > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      wr_gap--; rd_gap--;
      wr_en = 1'b0;
      if (wr_left > 0 && wr_gap <= 0) begin
        wr_en = 1'b1;
        addr_wr = 5'($urandom_range(31, 0));
        data_wr = $urandom;
        wr_left--;
        wr_gap = int'($urandom_range(3, 1));
      end
      if (rd_left > 0 && rd_gap <= 0) begin
        addr_rd1 = 5'($urandom_range(31, 0));
        addr_rd2 = ($urandom_range(1, 0) == 1) ? addr_wr : 5'($urandom_range(31, 0));
        #1;
        chk($sformatf("rand%0d_rd1", 10 - rd_left), data_rd1,
            exp_rd(addr_rd1, wr_en, addr_wr, data_wr));
        chk($sformatf("rand%0d_rd2", 10 - rd_left), data_rd2,
            exp_rd(addr_rd2, wr_en, addr_wr, data_wr));
        rd_left--;
        rd_gap = int'($urandom_range(4, 1));
      end
      @(posedge clk);
      if (wr_en && addr_wr != 5'd0) model[addr_wr] = data_wr;
    end
    n_checks++;
    if (wr_left != 0 || rd_left != 0) begin
      n_errors++;
      $display("FAIL rand_budget: got %0d pending, required 0", wr_left + rd_left);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
